// File: rtl/hd44780_bus_arbiter_if.sv
// rtl/hd44780_bus_arbiter_if.sv - requester handshake and HD44780 4-bit bus bundle
interface hd44780_bus_arbiter_if;
  logic       hold;
  logic       valid0;
  logic       valid1;
  logic       rs0;
  logic       rs1;
  logic [7:0] byte0;
  logic [7:0] byte1;
  logic       ready0;
  logic       ready1;
  logic       done0;
  logic       done1;
  logic       busy;
  logic       e;
  logic       rs;
  logic [3:0] db;

  modport master (
    output hold, valid0, valid1, rs0, rs1, byte0, byte1,
    input  ready0, ready1, done0, done1, busy, e, rs, db
  );

  modport slave (
    input  hold, valid0, valid1, rs0, rs1, byte0, byte1,
    output ready0, ready1, done0, done1, busy, e, rs, db
  );
endinterface

// File: rtl/hd44780_bus_arbiter.sv
// rtl/hd44780_bus_arbiter.sv - two-requester arbiter driving an HD44780 in 4-bit mode
module hd44780_bus_arbiter #(
  parameter int E_HIGH      = 10,
  parameter int NIBBLE_GAP  = 10,
  parameter int CMD_DELAY   = 20,
  parameter int CLEAR_DELAY = 2500
) (
  input  logic                   clk,
  input  logic                   rst,
  hd44780_bus_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, HI_E, HI_GAP, LO_E, WAIT} state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] cnt;
  logic [15:0] cnt_nx;

  // last = 1 means requester 1 was granted most recently
  logic        last;
  logic        id_l;
  logic        rs_l;
  logic        long_l;
  logic [7:0]  byte_l;

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        acc_id;
  logic        acc_rs;
  logic        acc_long;
  logic [7:0]  acc_byte;
  logic        sel_rs;
  logic [7:0]  sel_byte;

  logic        e_q;
  logic        rs_q;
  logic [3:0]  db_q;

  // Output decode: round-robin grant, handshake strobes, status pulses
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst && state == IDLE && !bus.hold) begin
      if (bus.valid0 && bus.valid1) begin
        grant0 = last;
        grant1 = !last;
      end else begin
        grant0 = bus.valid0;
        grant1 = bus.valid1;
      end
    end
    accept   = grant0 || grant1;
    acc_id   = grant1;
    acc_rs   = grant1 ? bus.rs1 : bus.rs0;
    acc_byte = grant1 ? bus.byte1 : bus.byte0;
    // Clear display and return home need the long settle time
    acc_long = !acc_rs && (acc_byte == 8'h01 || acc_byte == 8'h02);
    sel_rs   = accept ? acc_rs : rs_l;
    sel_byte = accept ? acc_byte : byte_l;
    bus.ready0 = grant0;
    bus.ready1 = grant1;
    bus.busy   = (state != IDLE);
    bus.done0  = (state == WAIT) && (cnt == 16'd1) && !id_l;
    bus.done1  = (state == WAIT) && (cnt == 16'd1) && id_l;
  end

  // Next state: every entry reloads the counter, leaving at count 1 so it never wraps
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = HI_E;
          cnt_nx   = 16'(E_HIGH);
        end
      end
      HI_E: begin
        cnt_nx = cnt - 16'd1;
        if (cnt == 16'd1) begin
          state_nx = HI_GAP;
          cnt_nx   = 16'(NIBBLE_GAP);
        end
      end
      HI_GAP: begin
        cnt_nx = cnt - 16'd1;
        if (cnt == 16'd1) begin
          state_nx = LO_E;
          cnt_nx   = 16'(E_HIGH);
        end
      end
      LO_E: begin
        cnt_nx = cnt - 16'd1;
        if (cnt == 16'd1) begin
          state_nx = WAIT;
          cnt_nx   = long_l ? 16'(CLEAR_DELAY) : 16'(CMD_DELAY);
        end
      end
      WAIT: begin
        cnt_nx = cnt - 16'd1;
        if (cnt == 16'd1) begin
          state_nx = IDLE;
          cnt_nx   = 16'd0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 16'd0;
      end
    endcase
  end

  // State register plus the byte captured at accept
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 16'd0;
      last   <= 1'b1;
      id_l   <= 1'b0;
      rs_l   <= 1'b0;
      long_l <= 1'b0;
      byte_l <= 8'h00;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        last   <= acc_id;
        id_l   <= acc_id;
        rs_l   <= acc_rs;
        long_l <= acc_long;
        byte_l <= acc_byte;
      end
    end
  end

  // Bus pins registered from the upcoming state so they align with it and never glitch
  always_ff @(posedge clk) begin
    if (!rst) begin
      e_q  <= 1'b0;
      rs_q <= 1'b0;
      db_q <= 4'h0;
    end else begin
      case (state_nx)
        HI_E, HI_GAP: begin
          e_q  <= (state_nx == HI_E);
          rs_q <= sel_rs;
          db_q <= sel_byte[7:4];
        end
        LO_E, WAIT: begin
          e_q  <= (state_nx == LO_E);
          rs_q <= sel_rs;
          db_q <= sel_byte[3:0];
        end
        default: begin
          e_q  <= 1'b0;
          rs_q <= 1'b0;
          db_q <= 4'h0;
        end
      endcase
    end
  end

  assign bus.e  = e_q;
  assign bus.rs = rs_q;
  assign bus.db = db_q;

endmodule

// File: tb/tb_hd44780_bus_arbiter.sv
// tb/tb_hd44780_bus_arbiter.sv - scoreboard bench for hd44780_bus_arbiter
module tb_hd44780_bus_arbiter;
  localparam int EH  = 10;
  localparam int NG  = 10;
  localparam int CD  = 20;
  localparam int CLR = 2500;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hd44780_bus_arbiter_if bus();

  hd44780_bus_arbiter #(
    .E_HIGH(EH), .NIBBLE_GAP(NG), .CMD_DELAY(CD), .CLEAR_DELAY(CLR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         id;
    logic       rs;
    logic [7:0] b;
    int         dly;
    int         gap;
    int         abs_cyc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   k        = 0;
  int   last_acc = -1;
  bit   active   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: checks every cycle, pops an expected byte on each accept
  always @(negedge clk) begin
    int         t;
    logic       ee;
    logic [3:0] edb;
    cyc++;
    if (active) begin
      k++;
      t   = 2*EH + NG + cur.dly;
      ee  = (k <= EH) || (k > EH+NG && k <= 2*EH+NG);
      edb = (k <= EH+NG) ? cur.b[7:4] : cur.b[3:0];
      chk("xfer", {bus.e, bus.rs, bus.db, bus.busy, bus.done0, bus.done1, bus.ready0, bus.ready1},
                  {ee, cur.rs, edb, 1'b1, (k == t) && cur.id == 0, (k == t) && cur.id == 1, 2'b00});
      if (k == t) active = 1'b0;
    end else begin
      chk("idle", {bus.e, bus.rs, bus.db, bus.busy, bus.done0, bus.done1}, 0);
    end
    if (!rst) begin
      active   = 1'b0;
      last_acc = -1;
      chk("rst_ready", {bus.ready0, bus.ready1}, 0);
    end else if ((bus.valid0 && bus.ready0) || (bus.valid1 && bus.ready1)) begin
      chk("one_ready", bus.ready0 && bus.ready1, 0);
      chk("no_overlap", active, 0);
      chk("exp_avail", q.size() > 0, 1);
      if (q.size() > 0) begin
        cur = q.pop_front();
        chk("grant_id", bus.ready1, cur.id);
        if (cur.gap > 0) chk("accept_gap", cyc - last_acc, cur.gap);
        if (cur.abs_cyc >= 0) chk("accept_cycle", cyc, cur.abs_cyc);
        last_acc = cyc;
        active   = 1'b1;
        k        = 0;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic r, input logic [7:0] b, input logic v);
    if (id == 0) begin
      bus.valid0 = v; bus.rs0 = r; bus.byte0 = b;
    end else begin
      bus.valid1 = v; bus.rs1 = r; bus.byte1 = b;
    end
  endtask

  // Waits for the requester's accept, then drops valid and scrambles the byte
  task automatic wait_accept(input int id);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 3000) begin
      @(negedge clk);
      got = (id == 0) ? bus.ready0 : bus.ready1;
      n++;
    end
    chk("accept_timeout", got, 1);
    @(posedge clk);
    #1;
    drive(id, 1'bx, 8'hA5, 1'b0);
  endtask

  task automatic issue(input int id, input logic r, input logic [7:0] b, input int dly);
    q.push_back('{id, r, b, dly, 0, -1});
    drive(id, r, b, 1'b1);
    wait_accept(id);
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((active || q.size() > 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_timeout", n < 3000, 1);
    wait_cycles(2);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.hold = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(2);

    // Clear display on requester 1: 2500-cycle wait, done at 2530
    issue(1, 1'b0, 8'h01, CLR);
    wait_drained();

    // Data byte 0x41 on requester 0; hold raised mid-transfer must not stretch it
    issue(0, 1'b1, 8'h41, CD);
    wait_cycles(15);
    bus.hold = 1'b1;
    wait_drained();
    bus.hold = 1'b0;

    // Delay-selection boundaries
    issue(0, 1'b1, 8'h01, CD);
    wait_drained();
    issue(1, 1'b0, 8'h02, CLR);
    wait_drained();
    issue(1, 1'b0, 8'h03, CD);
    wait_drained();
    issue(0, 1'b0, 8'h00, CD);
    wait_drained();

    // Hold blocks grants for 100 cycles; accept on the first cycle after release
    bus.hold = 1'b1;
    drive(0, 1'b1, 8'h5A, 1'b1);
    repeat (100) begin
      @(negedge clk);
      chk("hold_ready", bus.ready0, 0);
    end
    @(posedge clk);
    #1;
    q.push_back('{0, 1'b1, 8'h5A, CD, 0, cyc + 1});
    bus.hold = 1'b0;
    wait_accept(0);
    wait_drained();

    // Reset during LO_E aborts the byte; the next accept restarts cleanly
    issue(1, 1'b1, 8'h7E, CD);
    wait_cycles(22);
    rst = 1'b0;
    wait_cycles(1);
    rst = 1'b1;
    wait_cycles(5);
    issue(0, 1'b0, 8'h28, CD);
    wait_drained();

    // Tie from reset: pointer resets to 1, so order is 0,1,0,1 at 51-cycle spacing
    rst = 1'b0;
    drive(0, 1'b1, 8'h30, 1'b1);
    drive(1, 1'b0, 8'h28, 1'b1);
    q.push_back('{0, 1'b1, 8'h30, CD, 0, -1});
    q.push_back('{1, 1'b0, 8'h28, CD, 51, -1});
    q.push_back('{0, 1'b1, 8'h30, CD, 51, -1});
    q.push_back('{1, 1'b0, 8'h28, CD, 51, -1});
    wait_cycles(2);
    rst = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("tie_timeout", n < 1000, 1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    wait_drained();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
